// File: rtl/teras_pkg.sv
`default_nettype none
// ============================================================================
// Module   : teras_pkg
// Purpose  : Constants and helpers shared by the teras systolic-array top, its
//            row packer (upstream) and its output unpacker (downstream).
// Contents : ELEM_WIDTH  - posit<8,0> element width
//            N           - elements per row (array dimension)
//            POSIT_ZERO  - posit encoding of zero, used for row padding
//            eob_bit()   - bit position of the end-of-block tag in a word
//            sob_bit()   - bit position of the start-of-block tag in a word
// Revision : 1.0 - initial release
// ============================================================================
package teras_pkg;

    localparam int ELEM_WIDTH = 8;
    localparam int N          = 3;

    // posit<8,0> zero is the all-zeros pattern
    localparam logic [ELEM_WIDTH-1:0] POSIT_ZERO = '0;

    // Tags live in the two top bits of a row word
    function automatic int eob_bit(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int sob_bit(input int data_width);
        return data_width - 2;
    endfunction

endpackage : teras_pkg
`default_nettype wire

// File: rtl/teras_row_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : teras_row_packer_if
// Purpose  : Bundles the element stream (s_*) feeding the row packer and the
//            rts/rtr row-word handshake it presents toward teras.
// Modports : slave  - the row packer (consumes elements, produces words)
//            master - the environment (produces elements, consumes words)
// Revision : 1.0 - initial release
// ============================================================================
interface teras_row_packer_if #(
    parameter int ELEM_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [ELEM_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  rts_o;
    logic                  rtr_i;
    logic [DATA_WIDTH-1:0] data_o;

    modport slave (
        input  s_valid, s_data, s_last, rtr_i,
        output s_ready, rts_o, data_o
    );

    modport master (
        output s_valid, s_data, s_last, rtr_i,
        input  s_ready, rts_o, data_o
    );
endinterface : teras_row_packer_if
`default_nettype wire

// File: rtl/teras_row_packer.sv
`default_nettype none
// ============================================================================
// Module   : teras_row_packer
// Purpose  : Packs a byte-serial posit element stream into row words for the
//            teras A*A^T array, tagging first/last rows of each block with
//            SOB/EOB and zero-padding rows cut short by s_last.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - slave modport: s_valid/s_ready/s_data/s_last element
//                    input, rts_o/rtr_i/data_o row word output
// Revision : 1.0 - initial release
// ============================================================================
module teras_row_packer #(
    parameter int ELEM_WIDTH     = teras_pkg::ELEM_WIDTH,
    parameter int ELEMS_PER_ROW  = teras_pkg::N,
    parameter int ROWS_PER_BLOCK = 3,
    parameter int DATA_WIDTH     = 32
) (
    input  wire                logic clk,
    input  wire                logic rst_n,
    teras_row_packer_if.slave  bus
);
    import teras_pkg::*;

    localparam int EC_W    = $clog2(ELEMS_PER_ROW + 1);
    localparam int RC_W    = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
    localparam int SOB_POS = sob_bit(DATA_WIDTH);
    localparam int EOB_POS = eob_bit(DATA_WIDTH);

    localparam logic [EC_W-1:0]       ROW_ELEMS = EC_W'(ELEMS_PER_ROW);
    localparam logic [RC_W-1:0]       LAST_ROW  = RC_W'(ROWS_PER_BLOCK - 1);
    localparam logic [DATA_WIDTH-1:0] EMPTY_ROW =
        DATA_WIDTH'({ELEMS_PER_ROW{POSIT_ZERO}});

    // Assembler: partial row, or a finished tagged row waiting for the output
    // register when full_q is set.
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [EC_W-1:0]       elem_cnt_q, elem_cnt_d;
    logic [RC_W-1:0]       row_cnt_q, row_cnt_d;
    logic                  full_q, full_d;

    // One-entry output register
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;

    logic                  out_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] word;
    logic [EC_W-1:0]       cnt_next;
    logic                  row_done;
    logic                  eob;

    // Output register can take a new word if empty or being drained now
    assign out_free    = ~out_valid_q | bus.rtr_i;
    assign bus.s_ready = rst_n & ~(full_q & ~out_free);
    assign accept      = bus.s_valid & bus.s_ready;
    assign bus.rts_o   = out_valid_q;
    assign bus.data_o  = out_q;

    always_comb begin
        asm_d       = asm_q;
        elem_cnt_d  = elem_cnt_q;
        row_cnt_d   = row_cnt_q;
        full_d      = full_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        word        = '0;
        cnt_next    = '0;
        row_done    = 1'b0;
        eob         = 1'b0;

        if (out_valid_q && bus.rtr_i) begin
            out_valid_d = 1'b0;
        end

        // A held finished row moves out, freeing the assembler this cycle
        if (full_q && out_free) begin
            out_d       = asm_q;
            out_valid_d = 1'b1;
            full_d      = 1'b0;
            asm_d       = EMPTY_ROW;
            elem_cnt_d  = '0;
        end

        if (accept) begin
            word = asm_d;
            for (int k = 0; k < ELEMS_PER_ROW; k++) begin
                if (elem_cnt_d == EC_W'(k)) begin
                    word[k*ELEM_WIDTH +: ELEM_WIDTH] = bus.s_data;
                end
            end
            cnt_next = elem_cnt_d + EC_W'(1);
            row_done = (cnt_next == ROW_ELEMS) || bus.s_last;

            if (row_done) begin
                eob              = (row_cnt_q == LAST_ROW) || bus.s_last;
                word[SOB_POS]    = (row_cnt_q == '0);
                word[EOB_POS]    = eob;
                row_cnt_d        = eob ? '0 : row_cnt_q + RC_W'(1);
                elem_cnt_d       = '0;
                // Straight to the output unless a held row just claimed it
                if (out_free && !full_q) begin
                    out_d       = word;
                    out_valid_d = 1'b1;
                    asm_d       = EMPTY_ROW;
                end else begin
                    asm_d  = word;
                    full_d = 1'b1;
                end
            end else begin
                asm_d      = word;
                elem_cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= EMPTY_ROW;
            elem_cnt_q  <= '0;
            row_cnt_q   <= '0;
            full_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            elem_cnt_q  <= elem_cnt_d;
            row_cnt_q   <= row_cnt_d;
            full_q      <= full_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule : teras_row_packer
`default_nettype wire

// File: tb/tb_teras_row_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_teras_row_packer
// Purpose  : Self-checking bench for teras_row_packer: directed vector table,
//            backpressure and mid-stream reset sequences, and a randomized
//            run checked by a block-level reference scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_teras_row_packer;

    localparam int EW   = 8;
    localparam int EPR  = 3;
    localparam int RPB  = 3;
    localparam int DW   = 32;

    logic clk;
    logic rst_n;

    teras_row_packer_if #(.ELEM_WIDTH(EW), .DATA_WIDTH(DW)) bus ();

    teras_row_packer #(
        .ELEM_WIDTH    (EW),
        .ELEMS_PER_ROW (EPR),
        .ROWS_PER_BLOCK(RPB),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: elements gathered per row, row index inside block,
    // expected words in order of completion.
    // ------------------------------------------------------------------
    logic [EW-1:0] row_q[$];
    logic [DW-1:0] exp_q[$];
    int            blk_row     = 0;
    int            blocks_done = 0;

    task automatic model_clear();
        row_q.delete();
        exp_q.delete();
        blk_row = 0;
    endtask

    // Handshakes are evaluated at negedge, where inputs are stable until the
    // next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.s_valid && bus.s_ready) begin
                row_q.push_back(bus.s_data);
                if (bus.s_last) blocks_done++;
                if (row_q.size() == EPR || bus.s_last) begin
                    logic [DW-1:0] w;
                    bit            eob;
                    w = '0;
                    foreach (row_q[k]) w[k*EW +: EW] = row_q[k];
                    eob     = (blk_row == RPB - 1) || bus.s_last;
                    w[DW-1] = eob;
                    w[DW-2] = (blk_row == 0);
                    blk_row = eob ? 0 : blk_row + 1;
                    exp_q.push_back(w);
                    row_q.delete();
                end
            end
            if (bus.rts_o && bus.rtr_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra_word: got %h, wanted no word", bus.data_o);
                end else begin
                    check("sb_word", bus.data_o, exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n       = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        bus.s_last  = 1'b0;
        bus.rtr_i   = 1'b0;
        model_clear();
        @(posedge clk); #1;
        check("reset_rts",    {31'd0, bus.rts_o},   32'd0);
        check("reset_data",   bus.data_o,           32'd0);
        check("reset_sready", {31'd0, bus.s_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
    endtask

    // Present one element until accepted; returns at edge+1 after acceptance
    task automatic send_elem(input logic [7:0] d, input bit l);
        bit done = 0;
        int n    = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!done && n < 50) begin
            @(negedge clk);
            done = bus.s_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.s_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.s_valid = 1'b0;
        bus.rtr_i   = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check(name, exp_q.size(), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        last;
        logic        exp_v;
        logic [31:0] exp_w;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] d, input logic l, input logic v, input logic [31:0] w);
        vec_t t;
        t.d = d; t.last = l; t.exp_v = v; t.exp_w = w;
        vecs.push_back(t);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.rtr_i   = 1'b0;

        // Directed table: element in, expected word the cycle after it
        add_vec(8'h01, 0, 0, 0); add_vec(8'h02, 0, 0, 0); add_vec(8'h03, 0, 1, 32'h4003_0201);
        add_vec(8'h04, 0, 0, 0); add_vec(8'h05, 0, 0, 0); add_vec(8'h06, 0, 1, 32'h0006_0504);
        add_vec(8'h07, 0, 0, 0); add_vec(8'h08, 0, 0, 0); add_vec(8'h09, 1, 1, 32'h8009_0807);
        add_vec(8'h01, 0, 0, 0); add_vec(8'h02, 0, 0, 0); add_vec(8'h03, 0, 1, 32'h4003_0201);
        add_vec(8'h04, 0, 0, 0); add_vec(8'h05, 0, 0, 0); add_vec(8'h06, 0, 1, 32'h0006_0504);
        add_vec(8'h07, 0, 0, 0); add_vec(8'h08, 0, 0, 0); add_vec(8'h09, 0, 1, 32'h8009_0807);
        add_vec(8'h11, 0, 0, 0); add_vec(8'h22, 1, 1, 32'hC000_2211);
        add_vec(8'h0A, 0, 0, 0); add_vec(8'h0B, 0, 0, 0); add_vec(8'h0C, 0, 1, 32'h400C_0B0A);
        add_vec(8'h0D, 1, 1, 32'h8000_000D);

        do_reset();
        bus.rtr_i = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = vecs[i].d;
            bus.s_last  = vecs[i].last;
            @(posedge clk); #1;
            check("vec_rts", {31'd0, bus.rts_o}, {31'd0, vecs[i].exp_v});
            if (vecs[i].exp_v) check("vec_word", bus.data_o, vecs[i].exp_w);
        end
        drain("vec_drain");

        // Backpressure: rtr_i low while streaming one 9-element block
        do_reset();
        begin
            int v = 1;
            int n = 0;
            bit acc;
            bus.rtr_i = 1'b0;
            for (int c = 0; c < 16; c++) begin
                bus.s_valid = (v <= 9);
                bus.s_data  = 8'(v);
                bus.s_last  = (v == 9);
                @(negedge clk);
                acc = bus.s_valid && bus.s_ready;
                @(posedge clk); #1;
                if (acc) v++;
                if (c >= 4) check("stall_hold", bus.data_o, 32'h4003_0201);
            end
            check("stall_accepted", 32'(v - 1), 32'd6);
            check("stall_sready",   {31'd0, bus.s_ready}, 32'd0);
            check("stall_rts",      {31'd0, bus.rts_o},   32'd1);
            bus.rtr_i = 1'b1;
            while (v <= 9 && n < 40) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'(v);
                bus.s_last  = (v == 9);
                @(negedge clk);
                acc = bus.s_ready;
                @(posedge clk); #1;
                if (acc) v++;
                n++;
            end
            check("stall_resume", 32'(v), 32'd10);
            drain("stall_drain");
        end

        // Reset with a held word and two buffered elements
        do_reset();
        bus.rtr_i = 1'b0;
        for (int i = 1; i <= 5; i++) send_elem(8'(i), 1'b0);
        bus.s_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_rts",    {31'd0, bus.rts_o},   32'd0);
        check("midrst_data",   bus.data_o,           32'd0);
        check("midrst_sready", {31'd0, bus.s_ready}, 32'd0);
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus.rtr_i = 1'b1;
        send_elem(8'h31, 1'b0);
        send_elem(8'h32, 1'b0);
        send_elem(8'h33, 1'b0);
        check("midrst_first_rts",  {31'd0, bus.rts_o}, 32'd1);
        check("midrst_first_word", bus.data_o, 32'h4033_3231);
        drain("midrst_drain");

        // Randomized traffic against the scoreboard
        do_reset();
        blocks_done = 0;
        begin
            int cyc = 0;
            while (blocks_done < 1000 && cyc < 60000) begin
                bus.s_valid = 1'($urandom_range(0, 1));
                bus.s_data  = 8'($urandom);
                bus.s_last  = ($urandom_range(0, 5) == 0);
                bus.rtr_i   = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                cyc++;
            end
            check("rand_blocks", {31'd0, blocks_done >= 1000}, 32'd1);
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_teras_row_packer
`default_nettype wire
